sync_fifo: RTL and testbench

- Single-clock, parameterised word FIFO that buffers tester records between producer and consumer blocks in the same clock domain.
- Default build is the check FIFO: 52-bit records from the stimulus engine to the result checker.
- Also instantiated at 32 bits for the DUT-info FIFO.
- Normal (non-show-ahead) read mode, registered output, overflow and underflow protection.

---
 rtl/tester_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 32 +++
 rtl/sync_fifo.sv | 68 ++++++
 tb/tb_sync_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tester_pkg.sv
// Shared tester definitions: FIFO record widths and the packed record layouts
// that producer and consumer blocks agree on.
package tester_pkg;

  localparam int unsigned CFIFO_WIDTH  = 52;
  localparam int unsigned DIFIFO_WIDTH = 32;

  // Check record: stimulus engine -> result checker.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [31:0] expect_data;
  } check_rec_t;

  // DUT-info record: identification words captured from the device under test.
  typedef struct packed {
    logic [15:0] dev_id;
    logic [7:0]  revision;
    logic [7:0]  status;
  } dut_info_rec_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// whose output register clears asynchronously.
module fifo_ram #(
  parameter int unsigned WIDTH = 52,
  parameter int unsigned AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register holds its value when no read is accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with registered output, non-show-ahead reads and
// overflow/underflow protection; flags decode from the registered count.
module sync_fifo
  import tester_pkg::*;
#(
  parameter int unsigned WIDTH      = CFIFO_WIDTH,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  rdempty,
  output logic                  wrempty,
  output logic                  wrfull,
  output logic [DEPTH_LOG2:0]   usedw
);

  localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // A write into an empty FIFO never collides with a read: the read is refused.
  assign w_wr_acc = wrreq && (r_count != C_DEPTH);
  assign w_rd_acc = rdreq && (r_count != '0);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_rd_acc) r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (clock),
    .i_rst   (aclr),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr),
    .o_rdata (q)
  );

  assign rdempty = (r_count == '0);
  assign wrempty = (r_count == '0);
  assign wrfull  = (r_count == C_DEPTH);
  assign usedw   = r_count;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_sync_fifo;

  logic        clock = 1'b0;
  logic        aclr  = 1'b1;
  logic [51:0] data  = '0;
  logic        wrreq = 1'b0;
  logic        rdreq = 1'b0;
  logic [51:0] q;
  logic        rdempty, wrempty, wrfull;
  logic [3:0]  usedw;

  logic [31:0] d32    = '0;
  logic        wr32   = 1'b0;
  logic        rd32   = 1'b0;
  logic [31:0] q32;
  logic        rdempty32, wrempty32, wrfull32;
  logic [3:0]  usedw32;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sync_fifo dut (
    .clock   (clock),
    .aclr    (aclr),
    .data    (data),
    .wrreq   (wrreq),
    .rdreq   (rdreq),
    .q       (q),
    .rdempty (rdempty),
    .wrempty (wrempty),
    .wrfull  (wrfull),
    .usedw   (usedw)
  );

  sync_fifo #(.WIDTH(32), .DEPTH_LOG2(3)) dut32 (
    .clock   (clock),
    .aclr    (aclr),
    .data    (d32),
    .wrreq   (wr32),
    .rdreq   (rd32),
    .q       (q32),
    .rdempty (rdempty32),
    .wrempty (wrempty32),
    .wrfull  (wrfull32),
    .usedw   (usedw32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the last word read out.
  logic [51:0] mq[$];
  logic [51:0] mdout = '0;

  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      mq.delete();
      mdout = '0;
    end else begin
      bit wr_ok, rd_ok;
      wr_ok = wrreq && (mq.size() < 8);
      rd_ok = rdreq && (mq.size() > 0);
      if (rd_ok) mdout = mq.pop_front();
      if (wr_ok) mq.push_back(data);
    end
  end

  always @(negedge clock) begin
    chk("model_q",       64'(q),       64'(mdout));
    chk("model_usedw",   64'(usedw),   64'(mq.size()));
    chk("model_rdempty", 64'(rdempty), 64'(mq.size() == 0));
    chk("model_wrempty", 64'(wrempty), 64'(mq.size() == 0));
    chk("model_wrfull",  64'(wrfull),  64'(mq.size() == 8));
  end

  task automatic step(input logic w, input logic r, input logic [51:0] d);
    @(posedge clock);
    #1;
    wrreq = w;
    rdreq = r;
    data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_usedw",   64'(usedw),   64'd0);
    chk("rst_rdempty", 64'(rdempty), 64'd1);
    chk("rst_wrfull",  64'(wrfull),  64'd0);
    chk("rst_q",       64'(q),       64'd0);
    aclr = 1'b0;

    // Fill with 1..8.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 52'(i));
    step(1'b0, 1'b0, '0);
    chk("fill_usedw",  64'(usedw),  64'd8);
    chk("fill_wrfull", 64'(wrfull), 64'd1);

    // Write while full, with a read in the same cycle: write dropped.
    step(1'b1, 1'b1, 52'hDEAD);
    step(1'b0, 1'b0, '0);
    chk("ovf_usedw", 64'(usedw), 64'd7);
    chk("ovf_q",     64'(q),     64'd1);

    // Drain the rest: each word appears one cycle after its request.
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_q", 64'(q), 64'(k + 1));
    end
    step(1'b0, 1'b0, '0);
    chk("drain_q_last",  64'(q),       64'd8);
    chk("drain_rdempty", 64'(rdempty), 64'd1);

    // Underflow: last q = 5, then three reads on an empty FIFO.
    step(1'b1, 1'b1, 52'h5);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("unf_setup_q", 64'(q), 64'h5);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("unf_q",     64'(q),     64'h5);
    chk("unf_usedw", 64'(usedw), 64'd0);

    // Clear mid-operation with three words stored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 52'(16'hA1 + i));
    step(1'b0, 1'b0, '0);
    chk("pre_clr_usedw", 64'(usedw), 64'd3);
    @(negedge clock);
    #1;
    aclr = 1'b1;
    #1;
    chk("clr_rdempty", 64'(rdempty), 64'd1);
    chk("clr_wrempty", 64'(wrempty), 64'd1);
    chk("clr_wrfull",  64'(wrfull),  64'd0);
    chk("clr_usedw",   64'(usedw),   64'd0);
    chk("clr_q",       64'(q),       64'd0);
    @(posedge clock);
    #1;
    aclr = 1'b0;
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("post_clr_q",     64'(q),     64'd0);
    chk("post_clr_usedw", 64'(usedw), 64'd0);

    // Steady state: 4 stored, 20 simultaneous read+write, crosses two wraps.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 52'(100 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 52'(104 + i));
      if (i > 0) begin
        chk("sim_usedw", 64'(usedw), 64'd4);
        chk("sim_q",     64'(q),     64'(100 + i - 1));
      end
    end
    step(1'b0, 1'b0, '0);
    chk("sim_end_q",     64'(q),     64'd119);
    chk("sim_end_usedw", 64'(usedw), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("sim_drain_q",       64'(q),       64'd123);
    chk("sim_drain_rdempty", 64'(rdempty), 64'd1);

    // 32-bit instance: all-ones then all-zeros, bit-exact.
    chk("w32_init_q", 64'(q32), 64'd0);
    @(posedge clock); #1; wr32 = 1'b1; d32 = 32'hFFFF_FFFF;
    @(posedge clock); #1; d32 = 32'h0000_0000;
    @(posedge clock); #1; wr32 = 1'b0; rd32 = 1'b1;
    chk("w32_usedw", 64'(usedw32), 64'd2);
    chk("w32_wrempty", 64'(wrempty32), 64'd0);
    @(posedge clock); #1;
    chk("w32_q_ones", 64'(q32), 64'hFFFF_FFFF);
    @(posedge clock); #1; rd32 = 1'b0;
    chk("w32_q_zeros",  64'(q32),       64'd0);
    chk("w32_rdempty",  64'(rdempty32), 64'd1);
    chk("w32_wrfull",   64'(wrfull32),  64'd0);

    repeat (2) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
